// File: rtl/ibt_scan_scheduler.sv
// Round-robin arbiter handing the shared IBT channel-select datapath to one of six requesters at a time.
// A grant is issued one cycle after REQ is seen in IDLE; ACK is awaited under a watchdog, and no new grant is issued while ENA is low or a transaction is open.
module ibt_scan_scheduler #(
    parameter int NCH     = 6,
    parameter int TMO_W   = 7,
    parameter int TMO_MAX = 127
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENA,
    input  logic [NCH-1:0]   REQ,
    input  logic             ACK,
    input  logic             CLR,
    output logic [2:0]       IBT,
    output logic             STB,
    output logic [NCH-1:0]   GNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [TMO_W-1:0] WCNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t     state;
    logic [2:0] ch;
    logic [2:0] ptr;
    logic [2:0] pick;
    logic       pick_vld;
    logic [2:0] cand;
    int         idx;

    function automatic logic [2:0] next_ch(input logic [2:0] c);
        return (c == 3'(NCH - 1)) ? 3'd0 : c + 3'd1;
    endfunction

    // Search starts at ptr and wraps, so the most recently served channel is checked last.
    always_comb begin
        pick     = 3'd0;
        pick_vld = 1'b0;
        cand     = 3'd0;
        idx      = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            cand = 3'(idx);
            if (!pick_vld && REQ[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            ch    <= 3'd0;
            ptr   <= 3'd0;
            IBT   <= 3'b000;
            STB   <= 1'b0;
            GNT   <= '0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            WCNT  <= '0;
        end else begin
            STB  <= 1'b0;
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ENA && pick_vld) begin
                        ch    <= pick;
                        IBT   <= pick + 3'd2;
                        STB   <= 1'b1;
                        GNT   <= NCH'(1) << pick;
                        WCNT  <= '0;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: state <= S_WAIT;
                S_WAIT: begin
                    // ACK takes precedence over a timeout landing in the same cycle.
                    if (ACK) begin
                        DONE  <= 1'b1;
                        ptr   <= next_ch(ch);
                        state <= S_DONE;
                    end else if (WCNT == TMO_W'(TMO_MAX)) begin
                        ERR   <= 1'b1;
                        IBT   <= 3'b000;
                        GNT   <= '0;
                        state <= S_ERR;
                    end else begin
                        WCNT <= WCNT + 1'b1;
                    end
                end
                S_DONE: begin
                    IBT   <= 3'b000;
                    GNT   <= '0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    // The timed-out channel drops to lowest priority once the error is cleared.
                    if (CLR) begin
                        ERR   <= 1'b0;
                        ptr   <= next_ch(ch);
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
